addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined two-operand integer add/subtract unit. It is the successor to the fixed 16-bit combinational subtractor. It adds configurable width, carry-split pipeline depth, add/sub mode with carry/borrow chaining, optional saturation, and status flags. It sits in the datapath between operand registers and result consumers, using a valid/ready handshake on both sides.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥ 2.
- STAGES, 1: pipeline depth; 1, 2 or 4; WIDTH must be divisible by STAGES.
- SAT, 0: 0 = wrap-around, 1 = unsigned saturation, 2 = signed (two's complement) saturation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B+cin; 1: A−B−cin (cin is borrow-in).
- cin  in  1  carry-in (add) / borrow-in (sub).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  WIDTH  result after optional saturation.
- carry  out  1  add: unsigned carry-out; sub: unsigned borrow-out (1 when A < B+cin).
- ovf  out  1  signed overflow of the unsaturated result.
- zero  out  1  result == 0 (after saturation).
- neg  out  1  result[WIDTH−1] (after saturation).

## Operation
- Arithmetic is computed as A + (sub ? ~B : B) + (sub ? !cin : cin), giving a WIDTH+1-bit sum. carry = sum[WIDTH] ^ sub.
- ovf: add: a, b same sign and result sign differs; sub: a, b differ in sign and result sign differs from a.
- Carry-split pipeline: the operation is split into STAGES slices of WIDTH/STAGES bits. Stage k adds slice k using the registered carry from stage k−1. Upper operand slices and lower result slices are carried forward in pipeline registers.
- sub and the operand MSBs travel with the beat for flag computation in the last stage.
- Saturation is applied in the last stage only.
  - SAT=1: add with carry → all-ones; sub with borrow → 0.
  - SAT=2: ovf with a positive true result → 0111…1; ovf with a negative true result → 1000…0.
  - SAT=0: wrap.
- Flags carry and ovf always report the unsaturated condition. zero and neg reflect the output result.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Global advance enable: adv = !out_valid || out_ready; in_ready = adv.
  - When adv=1, every stage register (data + per-stage valid bit) shifts one stage. When adv=0, all hold.
  - Bubbles are not compressed; they advance with the pipe.
- result and flags are stable while out_valid && !out_ready. No beat is lost or duplicated.
- Operands are sampled only on an accepted beat. a, b, sub and cin are don't-care otherwise.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES, given no stall.
- Throughput: one beat per cycle when out_ready is held 1.
- Stalls: out_ready=0 while out_valid=1 drops in_ready combinationally in the same cycle. in_ready depends combinationally on out_ready and out_valid only.
- Simultaneous accept and drain in the same cycle is legal; the pipe shifts and a full pipe sustains full rate.
- Reset:
  - On any edge with rst=1, all stage valid bits clear, out_valid=0, and result, carry, ovf, zero, neg = 0. Data registers are zeroed.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; nothing is emitted for them.
  - A beat presented in the same cycle as rst=1 is not accepted.
- STAGES=1: output register only; latency 1.

## Test plan
- WIDTH=16, STAGES=2, SAT=0: a=0x1234, b=0x0235, sub=1, cin=0 → after 2 cycles result=0x0FFF, carry=0, ovf=0, zero=0, neg=0.
- WIDTH=16, SAT=0, sub=1: a=0x0000, b=0x0001 → result=0xFFFF, carry=1, neg=1. Same with SAT=1 → result=0x0000, carry=1, zero=1.
- WIDTH=16, SAT=2, sub=0:
  - a=0x7FFF, b=0x0001 → result=0x7FFF, ovf=1.
  - a=0x8000, b=0xFFFF → result=0x8000, ovf=1, carry=1.
- Chaining, WIDTH=16, STAGES=4: sub=0, cin=1, a=0xFFFF, b=0x0000 → result=0x0000, carry=1, zero=1. Then sub=1, cin=1, a=0x0005, b=0x0005 → result=0xFFFF, carry=1.
- Backpressure, STAGES=2: stream 6 beats back-to-back; hold out_ready=0 for 3 cycles mid-stream → in_ready=0 during the hold; outputs in order, each exactly once, values equal to the reference model.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight → out_valid=0 and all outputs 0 the next cycle; no stale beat ever emitted; the next beat accepted has latency STAGES.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: carry-split slices, optional saturation, status flags,
// valid/ready on both sides with one global advance enable.
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 1,
    parameter int SAT    = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int SW = WIDTH / STAGES;

    // One pipeline beat. In the last register c/ovf/zero/s hold the final flags and result.
    typedef struct packed {
        logic             sub;
        logic             a_msb;
        logic             b_msb;
        logic             c;
        logic             ovf;
        logic             zero;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] s;
    } beat_t;

    beat_t             pipe_q [STAGES];
    beat_t             pipe_d [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   vld_chain;
    logic              adv;
    beat_t             in_beat;

    beat_t             cur;
    beat_t             fin;
    logic [SW:0]       psum;
    logic              fin_carry;
    logic              fin_ovf;
    logic [WIDTH-1:0]  fin_res;

    assign adv         = !vld_q[STAGES-1] || out_ready_i;
    assign in_ready_o  = adv;
    assign vld_chain   = {vld_q, in_valid_i};

    // Subtraction is folded into an add of ~B with inverted borrow as carry-in.
    always_comb begin
        // NOTE: every field gets a default first so no latch is inferred.
        in_beat       = '0;
        in_beat.sub   = sub_i;
        in_beat.a_msb = a_i[WIDTH-1];
        in_beat.b_msb = b_i[WIDTH-1];
        in_beat.c     = sub_i ? !cin_i : cin_i;
        in_beat.a     = a_i;
        in_beat.bx    = sub_i ? ~b_i : b_i;
    end

    always_comb begin
        // NOTE: cur is a blocking temporary; each iteration must see the previous stage's value.
        cur = in_beat;
        for (int k = 0; k < STAGES; k++) begin
            psum = {1'b0, cur.a[k*SW +: SW]} + {1'b0, cur.bx[k*SW +: SW]} + {{SW{1'b0}}, cur.c};
            pipe_d[k]                = cur;
            pipe_d[k].c              = psum[SW];
            pipe_d[k].s[k*SW +: SW]  = psum[SW-1:0];
            cur = pipe_q[k];
        end

        fin       = pipe_d[STAGES-1];
        fin_carry = fin.c ^ fin.sub;
        fin_ovf   = (fin.sub ? (fin.a_msb != fin.b_msb) : (fin.a_msb == fin.b_msb))
                    && (fin.s[WIDTH-1] != fin.a_msb);
        fin_res   = fin.s;
        // On signed overflow the true result always has the sign of A.
        if (SAT == 1 && fin_carry) begin
            fin_res = fin.sub ? '0 : '1;
        end else if (SAT == 2 && fin_ovf) begin
            fin_res = fin.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end

        pipe_d[STAGES-1].c    = fin_carry;
        pipe_d[STAGES-1].ovf  = fin_ovf;
        pipe_d[STAGES-1].s    = fin_res;
        pipe_d[STAGES-1].zero = (fin_res == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            // NOTE: data registers are cleared too so result and flags read 0 after reset.
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_chain[STAGES-1:0];
            // Bubbles keep their stale data; only the valid bit moves.
            for (int k = 0; k < STAGES; k++) begin
                if (vld_chain[k]) begin
                    pipe_q[k] <= pipe_d[k];
                end
            end
        end
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign result_o    = pipe_q[STAGES-1].s;
    assign carry_o     = pipe_q[STAGES-1].c;
    assign ovf_o       = pipe_q[STAGES-1].ovf;
    assign zero_o      = pipe_q[STAGES-1].zero;
    assign neg_o       = pipe_q[STAGES-1].s[WIDTH-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: four configurations share operands, directed
// vectors with hand-computed results, then backpressure and reset scenarios on STAGES=2.
module tb_addsub_pipe;

    localparam int NDUT     = 4;
    localparam int LAT [4]  = '{2, 1, 1, 4};
    localparam int SATV [4] = '{0, 1, 2, 0};

    typedef struct packed {
        logic        v;
        logic [15:0] r;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } obs_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [19:0] e0;
        logic [19:0] e1;
        logic [19:0] e2;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NDUT-1:0]  iv = '0;
    logic [NDUT-1:0]  ordy = '1;
    logic [15:0]      a = '0;
    logic [15:0]      b = '0;
    logic             sub = 1'b0;
    logic             cin = 1'b0;
    logic             in_rdy  [NDUT];
    logic             out_vld [NDUT];
    logic [15:0]      res     [NDUT];
    logic             car     [NDUT];
    logic             ov      [NDUT];
    logic             zr      [NDUT];
    logic             ng      [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        addsub_pipe #(.WIDTH(16), .STAGES(LAT[i]), .SAT(SATV[i])) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (iv[i]),
            .in_ready_o  (in_rdy[i]),
            .a_i         (a),
            .b_i         (b),
            .sub_i       (sub),
            .cin_i       (cin),
            .out_valid_o (out_vld[i]),
            .out_ready_i (ordy[i]),
            .result_o    (res[i]),
            .carry_o     (car[i]),
            .ovf_o       (ov[i]),
            .zero_o      (zr[i]),
            .neg_o       (ng[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic obs_t get_obs(input int i);
        return {out_vld[i], res[i], car[i], ov[i], zr[i], ng[i]};
    endfunction

    // Behavioural reference using plain integer arithmetic.
    function automatic obs_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic msub, input logic mcin, input int sat);
        int ua, ub, sa, sb, u, t;
        logic c, o;
        logic [15:0] r;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            u = ua + ub + int'(mcin);
            t = sa + sb + int'(mcin);
            c = (u > 65535);
        end else begin
            u = ua - ub - int'(mcin);
            t = sa - sb - int'(mcin);
            c = (u < 0);
        end
        r = u[15:0];
        o = (t > 32767) || (t < -32768);
        if (sat == 1 && c) r = msub ? 16'h0000 : 16'hFFFF;
        else if (sat == 2 && o) r = (t > 0) ? 16'h7FFF : 16'h8000;
        return {1'b1, r, c, o, (r == 16'h0000), r[15]};
    endfunction

    // Expected fields: {result, carry, ovf, zero, neg} for SAT=0 / 1 / 2.
    vec_t vecs [8] = '{
        '{16'h1234, 16'h0235, 1'b1, 1'b0, {16'h0FFF, 4'b0000}, {16'h0FFF, 4'b0000}, {16'h0FFF, 4'b0000}},
        '{16'h0000, 16'h0001, 1'b1, 1'b0, {16'hFFFF, 4'b1001}, {16'h0000, 4'b1010}, {16'hFFFF, 4'b1001}},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0101}, {16'h8000, 4'b0101}, {16'h7FFF, 4'b0100}},
        '{16'h8000, 16'hFFFF, 1'b0, 1'b0, {16'h7FFF, 4'b1100}, {16'hFFFF, 4'b1101}, {16'h8000, 4'b1101}},
        '{16'hFFFF, 16'h0000, 1'b0, 1'b1, {16'h0000, 4'b1010}, {16'hFFFF, 4'b1001}, {16'h0000, 4'b1010}},
        '{16'h0005, 16'h0005, 1'b1, 1'b1, {16'hFFFF, 4'b1001}, {16'h0000, 4'b1010}, {16'hFFFF, 4'b1001}},
        '{16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 4'b0100}, {16'h7FFF, 4'b0100}, {16'h8000, 4'b0101}},
        '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, {16'h8000, 4'b1101}, {16'h0000, 4'b1110}, {16'h7FFF, 4'b1100}}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t q[$];
        logic [15:0] ba [6];
        logic [15:0] bb [6];
        logic        bs [6];
        logic        bc [6];
        logic [19:0] e;
        int sent, got, cyc;

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset_out_d%0d", i), 32'(get_obs(i)), 32'd0);
            check($sformatf("reset_in_ready_d%0d", i), 32'(in_rdy[i]), 32'd1);
        end

        // Directed vectors, all configurations, latency and values.
        for (int vi = 0; vi < 8; vi++) begin
            @(negedge clk);
            iv   = '1;
            ordy = '1;
            a    = vecs[vi].a;
            b    = vecs[vi].b;
            sub  = vecs[vi].sub;
            cin  = vecs[vi].cin;
            @(negedge clk);
            iv = '0;
            for (int n = 1; n <= 4; n++) begin
                #1;
                for (int i = 0; i < NDUT; i++) begin
                    e = (SATV[i] == 0) ? vecs[vi].e0 : (SATV[i] == 1) ? vecs[vi].e1 : vecs[vi].e2;
                    if (n == LAT[i])
                        check($sformatf("v%0d_d%0d", vi, i), 32'(get_obs(i)), 32'({1'b1, e}));
                    else if (n < LAT[i])
                        check($sformatf("v%0d_d%0d_early_n%0d", vi, i, n), 32'(out_vld[i]), 32'd0);
                end
                if (n < 4) @(negedge clk);
            end
        end

        // Backpressure on STAGES=2: six beats, out_ready low for three cycles mid-stream.
        for (int k = 0; k < 6; k++) begin
            ba[k] = 16'($urandom);
            bb[k] = 16'($urandom);
            bs[k] = 1'($urandom);
            bc[k] = 1'($urandom);
        end
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            ordy[0] = !(cyc >= 4 && cyc <= 6);
            iv[0]   = (sent < 6);
            if (sent < 6) begin
                a   = ba[sent];
                b   = bb[sent];
                sub = bs[sent];
                cin = bc[sent];
            end
            #1;
            if (out_vld[0] && !ordy[0])
                check($sformatf("bp_stall_in_ready_c%0d", cyc), 32'(in_rdy[0]), 32'd0);
            if (out_vld[0] && ordy[0]) begin
                if (q.size() == 0) begin
                    check("bp_extra_beat", 32'(out_vld[0]), 32'd0);
                end else begin
                    check($sformatf("bp_beat%0d", got), 32'(get_obs(0)), 32'(q.pop_front()));
                    got++;
                end
            end
            if (iv[0] && in_rdy[0]) begin
                q.push_back(model(a, b, sub, cin, 0));
                sent++;
            end
            cyc++;
        end
        check("bp_all_beats_out", 32'(got), 32'd6);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_no_dup_%0d", k), 32'(out_vld[0]), 32'd0);
        end

        // Reset with two beats in flight.
        @(negedge clk);
        iv[0] = 1'b1; ordy[0] = 1'b1;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        a = 16'h3333; b = 16'h0001;
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b0; rst = 1'b1;
        #1;
        check("rst_pre_inflight", 32'(out_vld[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0; ordy[0] = 1'b1;
        #1;
        check("rst_flush_outputs", 32'(get_obs(0)), 32'd0);
        check("rst_in_ready", 32'(in_rdy[0]), 32'd1);
        iv[0] = 1'b1;
        a = 16'h0100; b = 16'h0011; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        check("rst_no_stale", 32'(out_vld[0]), 32'd0);
        @(negedge clk);
        #1;
        check("rst_new_beat", 32'(get_obs(0)), 32'({1'b1, 16'h0111, 4'b0000}));
        @(negedge clk);
        #1;
        check("rst_new_beat_once", 32'(out_vld[0]), 32'd0);

        // A beat presented together with reset must be dropped.
        @(negedge clk);
        rst = 1'b1; iv[0] = 1'b1;
        a = 16'h4444; b = 16'h0004;
        @(negedge clk);
        rst = 1'b0; iv[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("rst_beat_dropped_%0d", k), 32'(out_vld[0]), 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
